// File: rtl/array_proc_pkg.sv
// rtl/array_proc_pkg.sv - shared opcode, state and width definitions for the array sequencer
package array_proc_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 11;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_ADD  = 2'b01,
    OP_FILL = 2'b10,
    OP_RSVD = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/array_op_sequencer.sv
// rtl/array_op_sequencer.sv - COPY/ADD/FILL sequencer driving a dual-port BRAM
// Port A reads then writes each element; port B is used only as a second read port.
module array_op_sequencer
  import array_proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        opcode,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wea,
  output logic              web,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] dib,
  input  logic [DATA_W-1:0] doa,
  input  logic [DATA_W-1:0] dob
);

  state_e            r_state;
  state_e            w_state_nxt;
  opcode_e           r_op;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_fill;
  logic [LEN_W-1:0]  r_idx;
  logic              r_err;

  logic              w_accept;
  logic [LEN_W-1:0]  w_idx_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_ofs;
  logic [DATA_W-1:0] w_sum;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_idx_inc = r_idx + LEN_W'(1);
  assign w_last    = (w_idx_inc == r_len);
  assign w_ofs     = ADDR_W'(r_idx);
  assign w_sum     = doa + dob;
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command registers are captured only on accept, so inputs may change freely mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= OP_COPY;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= opcode_e'(opcode);
      r_src_a <= src_a;
      r_src_b <= src_b;
      r_dst   <= dst;
      r_len   <= len;
      r_fill  <= fill_val;
      r_idx   <= '0;
      r_err   <= (opcode_e'(opcode) == OP_RSVD);
    end else if ((r_state == S_WRITE) || (r_state == S_FILL)) begin
      r_idx   <= w_idx_inc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    wea         = 1'b0;
    web         = 1'b0;
    addra       = '0;
    addrb       = '0;
    dia         = '0;
    dib         = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((len == '0) || (opcode_e'(opcode) == OP_RSVD)) begin
            w_state_nxt = S_DONE;
          end else if (opcode_e'(opcode) == OP_FILL) begin
            w_state_nxt = S_FILL;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        busy        = 1'b1;
        addra       = r_src_a + w_ofs;
        addrb       = r_src_b + w_ofs;
        w_state_nxt = S_WRITE;
      end
      // doa/dob hold the words addressed during the preceding READ cycle.
      S_WRITE: begin
        busy        = 1'b1;
        wea         = 1'b1;
        addra       = r_dst + w_ofs;
        dia         = (r_op == OP_ADD) ? w_sum : doa;
        w_state_nxt = w_last ? S_DONE : S_READ;
      end
      S_FILL: begin
        busy        = 1'b1;
        wea         = 1'b1;
        addra       = r_dst + w_ofs;
        dia         = r_fill;
        w_state_nxt = w_last ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_array_op_sequencer.sv
// tb/tb_array_op_sequencer.sv - directed bench for array_op_sequencer with a read-first BRAM model
module tb_array_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [1:0]  opcode;
  logic [9:0]  src_a, src_b, dst;
  logic [10:0] len;
  logic [15:0] fill_val;
  logic        busy, done, err, wea, web;
  logic [9:0]  addra, addrb;
  logic [15:0] dia, dib, doa, dob;

  array_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .err(err), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .doa(doa), .dob(dob)
  );

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] mem [0:1023];
  wr_t         wr_log [$];
  bit          bad_idle = 1'b0;

  always @(posedge clk) begin
    doa <= mem[addra];
    dob <= mem[addrb];
    if (wea) begin
      mem[addra] = dia;
      wr_log.push_back('{addra, dia});
    end
  end

  always @(negedge clk) begin
    if ((web !== 1'b0) || (dib !== 16'h0) || ((wea === 1'b0) && (dia !== 16'h0)))
      bad_idle = 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pattern();
    for (int a = 0; a < 1024; a++) mem[a] = 16'h1000 + 16'(a);
  endtask

  // Issue one command, scramble the command inputs after accept, and time the done pulse.
  task automatic run_op(input logic [1:0] op, input logic [9:0] sa, input logic [9:0] sb,
                        input logic [9:0] d, input logic [10:0] ln, input logic [15:0] fv,
                        input int poke_at, output int lat, output bit bs, output logic e);
    @(negedge clk);
    opcode = op; src_a = sa; src_b = sb; dst = d; len = ln; fill_val = fv; start = 1'b1;
    wr_log.delete();
    bs = 1'b0;
    @(negedge clk);
    start = 1'b0; opcode = 2'b11; src_a = 10'h155; src_b = 10'h2AA; dst = 10'h0F0;
    len = 11'd7; fill_val = 16'hDEAD;
    lat = 1;
    while (!done && lat < 5000) begin
      if (busy) bs = 1'b1;
      start = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy) bs = 1'b1;
    e = err;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [9:0]  sa, sb, d;
    logic [10:0] ln;
    logic [15:0] fv;
    int          lat;
    logic        er;
    int          nwr;
    logic [9:0]  fa;
    logic [15:0] fd;
    logic [9:0]  la;
    logic [15:0] ld;
    logic        bz;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   lat;
    bit   bs;
    logic e;
    int   nw;
    int   cyc;

    vecs[0] = '{2'b00, 10'h005, 10'h000, 10'h200, 11'd3, 16'h0000, 7, 1'b0, 3, 10'h200, 16'h1005, 10'h202, 16'h1007, 1'b1};
    vecs[1] = '{2'b01, 10'h001, 10'h002, 10'h300, 11'd2, 16'h0000, 5, 1'b0, 2, 10'h300, 16'h2003, 10'h301, 16'h2005, 1'b1};
    vecs[2] = '{2'b10, 10'h000, 10'h000, 10'h010, 11'd1, 16'h1234, 2, 1'b0, 1, 10'h010, 16'h1234, 10'h010, 16'h1234, 1'b1};
    vecs[3] = '{2'b00, 10'h000, 10'h000, 10'h040, 11'd0, 16'h0000, 1, 1'b0, 0, 10'h000, 16'h0000, 10'h000, 16'h0000, 1'b0};
    vecs[4] = '{2'b11, 10'h000, 10'h000, 10'h040, 11'd5, 16'h0000, 1, 1'b1, 0, 10'h000, 16'h0000, 10'h000, 16'h0000, 1'b0};
    vecs[5] = '{2'b01, 10'h3FF, 10'h3FF, 10'h050, 11'd2, 16'h0000, 5, 1'b0, 2, 10'h050, 16'h27FE, 10'h051, 16'h2000, 1'b1};
    vecs[6] = '{2'b00, 10'h100, 10'h000, 10'h101, 11'd3, 16'h0000, 7, 1'b0, 3, 10'h101, 16'h1100, 10'h103, 16'h1100, 1'b1};
    vecs[7] = '{2'b10, 10'h000, 10'h000, 10'h060, 11'd0, 16'h5555, 1, 1'b0, 0, 10'h000, 16'h0000, 10'h000, 16'h0000, 1'b0};

    reset = 1'b0; start = 1'b0; opcode = 2'b00; src_a = '0; src_b = '0; dst = '0;
    len = '0; fill_val = '0;
    load_pattern();
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, err, wea, web, addra, addrb, dia, dib}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, wea}, 64'h0);

    for (int k = 0; k < 8; k++) begin
      load_pattern();
      run_op(vecs[k].op, vecs[k].sa, vecs[k].sb, vecs[k].d, vecs[k].ln, vecs[k].fv, 0, lat, bs, e);
      check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d_err", k), e, vecs[k].er);
      check($sformatf("v%0d_busy_seen", k), bs, vecs[k].bz);
      check($sformatf("v%0d_nwrites", k), wr_log.size(), vecs[k].nwr);
      if (vecs[k].nwr > 0 && wr_log.size() > 0) begin
        check($sformatf("v%0d_first_wr", k), {wr_log[0].a, wr_log[0].d}, {vecs[k].fa, vecs[k].fd});
        check($sformatf("v%0d_last_wr", k), {wr_log[wr_log.size()-1].a, wr_log[wr_log.size()-1].d},
              {vecs[k].la, vecs[k].ld});
      end
    end

    load_pattern();
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    run_op(2'b00, 10'h000, 10'h000, 10'h100, 11'd4, 16'h0, 0, lat, bs, e);
    check("copy4_latency", lat, 9);
    check("copy4_mem", {mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}, 64'h0001_0002_0003_0004);

    mem[10'h010] = 16'hFFFF; mem[10'h011] = 16'h0005; mem[10'h020] = 16'h0002; mem[10'h021] = 16'h0007;
    run_op(2'b01, 10'h010, 10'h020, 10'h030, 11'd2, 16'h0, 0, lat, bs, e);
    check("add2_latency", lat, 5);
    check("add2_mem", {mem[10'h030], mem[10'h031]}, 64'h0001_000C);

    run_op(2'b10, 10'h000, 10'h000, 10'h3FE, 11'd4, 16'hABCD, 0, lat, bs, e);
    check("fill_wrap_latency", lat, 5);
    check("fill_wrap_nwrites", wr_log.size(), 4);
    if (wr_log.size() == 4)
      check("fill_wrap_addrs", {wr_log[0].a, wr_log[1].a, wr_log[2].a, wr_log[3].a},
            {10'h3FE, 10'h3FF, 10'h000, 10'h001});
    check("fill_wrap_mem", {mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]}, 64'hABCD_ABCD_ABCD_ABCD);

    load_pattern();
    run_op(2'b00, 10'h000, 10'h000, 10'h200, 11'd8, 16'h0, 4, lat, bs, e);
    check("start_busy_ignored_latency", lat, 17);
    check("start_busy_ignored_nwrites", wr_log.size(), 8);
    check("start_busy_ignored_err", e, 1'b0);
    check("copy8_last", mem[10'h207], 16'h1007);

    run_op(2'b11, 10'h000, 10'h000, 10'h000, 11'd3, 16'h0, 0, lat, bs, e);
    check("rsvd_err", e, 1'b1);
    @(negedge clk);
    check("err_sticky_idle", {err, done}, 2'b10);

    load_pattern();
    @(negedge clk);
    opcode = 2'b00; src_a = 10'h000; dst = 10'h200; len = 11'd8; start = 1'b1;
    wr_log.delete();
    @(negedge clk);
    start = 1'b0;
    nw = 0;
    cyc = 0;
    while (cyc < 40) begin
      if (wea) nw++;
      if (nw == 3) break;
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_write", nw, 3);
    #1 reset = 1'b0;
    #1 check("rst_mid_outputs", {busy, done, err, wea, web, addra, addrb, dia, dib}, 64'h0);
    check("rst_mid_nwrites", wr_log.size(), 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_restart", {busy, done, wea}, 64'h0);
    check("rst_no_more_writes", wr_log.size(), 2);
    check("rst_aborted_word", mem[10'h202], 16'h1202);

    run_op(2'b00, 10'h005, 10'h000, 10'h080, 11'd1, 16'h0, 0, lat, bs, e);
    check("post_rst_latency", lat, 3);
    check("post_rst_mem", mem[10'h080], 16'h1005);

    check("web_dib_dia_idle", bad_idle, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
